// File: rtl/right_align_shifter.sv
// rtl/right_align_shifter.sv - nSel-stage pipelined logarithmic right shifter with valid/ready handshake.
// Optional sticky accumulation is compiled in with ALIGN_STICKY_EN.
module right_align_shifter #(
  parameter int N = 32,
  localparam int nSel = $clog2(N)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [N-1:0]    In,
  input  logic [nSel-1:0] ShiftAmount,
  input  logic            ShiftIn,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [N-1:0]    Out,
  output logic            Sticky
);

  logic advance;

  logic [nSel-1:0]         valid_q, valid_d, src_valid;
  logic [nSel-1:0][N-1:0]  data_q, data_d, src_data;
  logic [nSel-1:0]         src_fill;
  logic [nSel-1:0][nSel-1:0] src_amt;
  // The last stage needs neither the fill bit nor any remaining amount bits.
  logic [nSel-2:0]         fill_q, fill_d;
  logic [nSel-2:0][nSel-1:0] amt_q, amt_d;

  assign advance  = !(OutValid && !OutReady);
  assign InReady  = advance;
  assign OutValid = valid_q[nSel-1];
  assign Out      = data_q[nSel-1];

  always_comb begin
    src_data  = '0;
    src_fill  = '0;
    src_amt   = '0;
    src_valid = '0;
    data_d    = '0;
    fill_d    = '0;
    amt_d     = '0;
    src_data[0]  = In;
    src_fill[0]  = ShiftIn;
    src_amt[0]   = ShiftAmount;
    src_valid[0] = InValid;
    for (int k = 1; k < nSel; k++) begin
      src_data[k]  = data_q[k-1];
      src_fill[k]  = fill_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_valid[k] = valid_q[k-1];
    end
    valid_d = src_valid;
    // Amount is pre-shifted each stage so bit 0 always steers the current stage.
    for (int k = 0; k < nSel; k++) begin
      if (src_amt[k][0])
        data_d[k] = (src_data[k] >> (1 << k)) |
                    ({N{src_fill[k]}} & ~({N{1'b1}} >> (1 << k)));
      else
        data_d[k] = src_data[k];
    end
    for (int k = 0; k < nSel - 1; k++) begin
      fill_d[k] = src_fill[k];
      amt_d[k]  = src_amt[k] >> 1;
    end
  end

`ifdef ALIGN_STICKY_EN
  logic [nSel-1:0] sticky_q, sticky_d, src_sticky;

  always_comb begin
    src_sticky = '0;
    sticky_d   = '0;
    for (int k = 1; k < nSel; k++)
      src_sticky[k] = sticky_q[k-1];
    for (int k = 0; k < nSel; k++) begin
      sticky_d[k] = src_sticky[k];
      if (src_amt[k][0])
        sticky_d[k] = src_sticky[k] | (|(src_data[k] & ~({N{1'b1}} << (1 << k))));
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      sticky_q <= '0;
    else if (advance)
      sticky_q <= sticky_d;
  end

  assign Sticky = sticky_q[nSel-1];
`else
  assign Sticky = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      amt_q   <= '0;
    end else if (advance) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      amt_q   <= amt_d;
    end
  end

endmodule

// File: tb/tb_right_align_shifter.sv
// tb/tb_right_align_shifter.sv - directed self-checking bench for right_align_shifter (N = 32).
module tb_right_align_shifter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] In;
  logic [4:0]  ShiftAmount;
  logic        ShiftIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Out;
  logic        Sticky;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  right_align_shifter #(.N(32)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .In(In), .ShiftAmount(ShiftAmount), .ShiftIn(ShiftIn),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .Sticky(Sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic stk(input logic s);
`ifdef ALIGN_STICKY_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] d, input logic [4:0] a, input logic f);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (d >> a) | ({32{f}} & ~(ones >> a));
  endfunction

  function automatic logic ref_sticky(input logic [31:0] d, input logic [4:0] a);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return |(d & ~(ones << a));
  endfunction

  // Single operand through an idle pipe; OutValid must rise exactly 5 edges after acceptance.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] a,
                         input logic f, input logic [31:0] exp_out, input logic exp_stk);
    @(negedge Clock);
    OutReady = 1'b1;
    InValid = 1'b1; In = d; ShiftAmount = a; ShiftIn = f;
    #1 check({tag, "_inready"}, {31'd0, InReady}, 32'd1);
    @(posedge Clock);
    for (int j = 1; j <= 5; j++) begin
      @(negedge Clock);
      InValid = 1'b0;
      #1;
      if (j < 5) check({tag, "_early"}, {31'd0, OutValid}, 32'd0);
    end
    check({tag, "_valid"}, {31'd0, OutValid}, 32'd1);
    check({tag, "_out"}, Out, exp_out);
    check({tag, "_sticky"}, {31'd0, Sticky}, {31'd0, stk(exp_stk)});
  endtask

  logic [31:0] exp_q[$];
  logic        stk_q[$];

  initial begin
    logic [31:0] ops [8];
    logic [4:0]  amts [8];
    logic        fills [8];
    logic [31:0] held;
    logic        acc;
    logic        seen;
    int sent, got, cyc;

    Reset = 1'b1; InValid = 1'b0; In = '0; ShiftAmount = '0; ShiftIn = 1'b0; OutReady = 1'b1;
    held = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_inready", {31'd0, InReady}, 32'd1);
    check("rst_out", Out, 32'd0);
    check("rst_sticky", {31'd0, Sticky}, 32'd0);

    run_one("msb_by4",   32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 1'b0);
    run_one("f_by2",     32'h0000_000F, 5'd2,  1'b0, 32'h0000_0003, 1'b1);
    run_one("arith31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_one("zero_amt",  32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0);
    run_one("log31",     32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000, 1'b1);
    run_one("arith16",   32'hF0F0_F0F0, 5'd16, 1'b1, 32'hFFFF_F0F0, 1'b1);
    run_one("byte8",     32'h1234_5600, 5'd8,  1'b0, 32'h0012_3456, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ops[i]  = 32'h89AB_CDEF ^ (32'h1111_1111 * i);
      amts[i] = 5'(i * 3 + 1);
      fills[i] = i[0];
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 60) begin
      @(negedge Clock);
      OutReady = !(cyc >= 6 && cyc < 9);
      InValid = (sent < 8);
      if (sent < 8) begin
        In = ops[sent]; ShiftAmount = amts[sent]; ShiftIn = fills[sent];
      end
      #1;
      if (cyc >= 6 && cyc < 9) begin
        check("stall_inready", {31'd0, InReady}, 32'd0);
        check("stall_valid", {31'd0, OutValid}, 32'd1);
        if (cyc == 6) held = Out;
        else check("stall_hold", Out, held);
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", {31'd0, OutValid}, 32'd0);
        end else begin
          check("stream_out", Out, exp_q.pop_front());
          check("stream_sticky", {31'd0, Sticky}, {31'd0, stk(stk_q.pop_front())});
        end
        got++;
      end
      acc = InValid && InReady;
      @(posedge Clock);
      if (acc) begin
        exp_q.push_back(ref_out(ops[sent], amts[sent], fills[sent]));
        stk_q.push_back(ref_sticky(ops[sent], amts[sent]));
        sent++;
      end
      cyc++;
    end
    check("stream_count", got, 32'd8);
    check("stream_left", exp_q.size(), 32'd0);
    @(negedge Clock);
    InValid = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      seen = seen | OutValid;
    end
    check("stream_no_dup", {31'd0, seen}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      InValid = 1'b1; In = 32'hA5A5_0000 + i; ShiftAmount = 5'd1; ShiftIn = 1'b0;
      #1 check("pre_rst_accept", {31'd0, InReady}, 32'd1);
    end
    @(negedge Clock);
    Reset = 1'b1;
    In = 32'h0BAD_0BAD;
    @(negedge Clock);
    Reset = 1'b0; InValid = 1'b0;
    #1;
    check("mid_rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("mid_rst_inready", {31'd0, InReady}, 32'd1);
    check("mid_rst_out", Out, 32'd0);
    check("mid_rst_sticky", {31'd0, Sticky}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge Clock);
      seen = seen | OutValid;
    end
    check("mid_rst_flushed", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/right_align_shifter.md
RIGHT_ALIGN_SHIFTER -- requirements
Module: right_align_shifter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high, and the ports SHALL be named Clock and Reset.
REQ-002 Parameter N, default 32: data width; SHALL be a power of two, at least 4.
REQ-003 Localparam nSel = $clog2(N): shift-amount width and pipeline depth.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-high; clears all valid state.
REQ-006 InValid  input  1  the source presents a valid operand.
REQ-007 InReady  output  1  the block accepts the operand this cycle.
REQ-008 In  input  N  operand to shift right.
REQ-009 ShiftAmount  input  nSel  right-shift distance, 0..N-1.
REQ-010 ShiftIn  input  1  fill bit entering at the MSB (0 = logical shift, sign = arithmetic shift).
REQ-011 OutValid  output  1  Out and Sticky hold a valid result.
REQ-012 OutReady  input  1  the sink accepts the result this cycle.
REQ-013 Out  output  N  In shifted right by ShiftAmount, vacated MSBs filled with ShiftIn.
REQ-014 Sticky  output  1  OR of every bit shifted out past the LSB.

Function
REQ-015 The datapath SHALL be a logarithmic right shifter of nSel registered stages; stage k (k = 0..nSel-1) shifts by 2^k when ShiftAmount bit k is 1, otherwise passes through.
REQ-016 Each stage register SHALL carry its data, the ShiftIn bit, the unused upper ShiftAmount bits, the partial sticky and a valid bit.
REQ-017 Stage k partial sticky SHALL equal the previous partial sticky ORed with the 2^k LSBs discarded at stage k.
REQ-018 The pipeline SHALL advance when Advance = !(OutValid && !OutReady); all stages SHALL hold when Advance is 0.
REQ-019 InReady SHALL equal Advance.
REQ-020 An operand SHALL be accepted on a cycle with InValid && InReady.
REQ-021 Latency SHALL be exactly nSel cycles from acceptance to OutValid, provided there is no stall.
REQ-022 Throughput SHALL be one operand per cycle while OutReady is held at 1.
REQ-023 When a stage advances with no valid input, the valid bit behind it SHALL become 0 (bubble); bubbles SHALL NOT collapse under stall.
REQ-024 While OutValid && !OutReady, Out, Sticky and OutValid SHALL remain stable.
REQ-025 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-026 ShiftAmount = 0 SHALL give Out = In and Sticky = 0.
REQ-027 ShiftAmount = N-1 SHALL give Out = {N-1 copies of ShiftIn, In[N-1]} and Sticky = OR of In[N-2:0].
REQ-028 If InValid and OutReady are both 0 while OutValid is 1, the block SHALL hold and SHALL accept nothing.

Reset
REQ-029 Reset SHALL clear all stage valid bits, so that OutValid = 0 and InReady = 1 on the cycle after Reset is sampled.
REQ-030 Data, sticky and amount registers SHALL reset to 0, so that Out = 0 and Sticky = 0 after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands; none SHALL ever appear on Out.
REQ-032 An operand presented in the same cycle that Reset is sampled SHALL NOT be accepted.

Configuration
REQ-033 Macro ALIGN_STICKY_EN defined: sticky accumulation SHALL be compiled in and Sticky SHALL behave per REQ-014 and REQ-017.
REQ-034 Macro ALIGN_STICKY_EN undefined: no sticky registers or OR logic SHALL exist and Sticky SHALL be tied to 0.
REQ-035 All other behaviour SHALL be identical with and without ALIGN_STICKY_EN.

Verification (N = 32, nSel = 5, OutReady = 1 unless stated)
REQ-036 In = 0x80000000, ShiftAmount = 4, ShiftIn = 0 -> after 5 cycles Out = 0x08000000, Sticky = 0.
REQ-037 In = 0x0000000F, ShiftAmount = 2, ShiftIn = 0 -> Out = 0x00000003, Sticky = 1 (0 with ALIGN_STICKY_EN undefined).
REQ-038 In = 0x80000000, ShiftAmount = 31, ShiftIn = 1 -> Out = 0xFFFFFFFF, Sticky = 0.
REQ-039 Stream 8 back-to-back operands with OutReady low for 3 cycles mid-stream -> InReady low during the stall, Out held stable, all 8 results in order, none duplicated.
REQ-040 Accept 3 operands, assert Reset for 1 cycle at cycle 2 -> OutValid = 0 thereafter, InReady = 1, none of the 3 results ever emitted.
REQ-041 ShiftAmount = 0, In = 0xDEADBEEF -> Out = 0xDEADBEEF, Sticky = 0, latency exactly 5 cycles.
